// File: rtl/ring_cntr_pkg.sv
// rtl/ring_cntr_pkg.sv - mode type, mode constants and start-value helper for the ring/Johnson counter
package ring_cntr_pkg;

  // Widest counter the start-value helper can describe; callers size-cast the result to N.
  localparam int START_W = 64;

  typedef enum logic {
    MODE_TWIST = 1'b0,
    MODE_RING  = 1'b1
  } mode_t;

  // Johnson sequences start at all-zeros; one-hot rings start with bit 0 set.
  function automatic logic [START_W-1:0] start_val(input mode_t m);
    logic [START_W-1:0] v;
    v    = '0;
    v[0] = (m == MODE_RING);
    return v;
  endfunction

endpackage

// File: rtl/ring_cntr_phase_dec.sv
// rtl/ring_cntr_phase_dec.sv - combinational phase decode and legality check for the ring/Johnson counter
//
// Ports:
//   cntr  (in,  N)  : current counter state
//   mode  (in,  1)  : registered mode the state is interpreted under
//   phase (out, PW) : position of cntr in its sequence, 0 when err is high
//   err   (out, 1)  : cntr is not a legal state for mode
module ring_cntr_phase_dec
  import ring_cntr_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(2*N)
) (
  input  logic [N-1:0]  cntr,
  input  mode_t         mode,
  output logic [PW-1:0] phase,
  output logic          err
);

  int ones;
  int trans;
  int idx;
  int ph;

  always_comb begin
    ones  = 0;
    trans = 0;
    idx   = 0;
    ph    = 0;
    err   = 1'b0;
    for (int i = 0; i < N; i++) begin
      ones = ones + int'(cntr[i]);
      if (cntr[i]) idx = i;
    end
    // A Johnson pattern is a single run of ones anchored at one end, so it has
    // at most one boundary between adjacent bits; that set is exactly 2N states.
    for (int i = 0; i < N - 1; i++) begin
      if (cntr[i] != cntr[i+1]) trans = trans + 1;
    end
    if (mode == MODE_TWIST) begin
      err = (trans > 1);
      // The fill half (lsb still 0) counts ones; the drain half counts down from 2N.
      ph  = cntr[0] ? (2*N - ones) : ones;
    end else begin
      err = (ones != 1);
      ph  = (N - idx) % N;
    end
    phase = err ? '0 : PW'(ph);
  end

endmodule

// File: rtl/cfg_ring_cntr.sv
// rtl/cfg_ring_cntr.sv - configurable Johnson / one-hot ring counter with phase, wrap and error outputs
//
// Build option: CFG_RING_CNTR_SELF_CORRECT_EN - when defined, an illegal state
// is replaced by the start value on the next edge; otherwise it persists.
//
// Ports:
//   clk      (in,  1)  : clock, rising edge
//   rst      (in,  1)  : synchronous active-high reset
//   en       (in,  1)  : advance one step
//   dir      (in,  1)  : 0 = shift right, 1 = shift left
//   mode     (in,  1)  : MODE_TWIST (Johnson) or MODE_RING (one-hot)
//   load     (in,  1)  : write load_val on the next edge
//   load_val (in,  N)  : value written on load
//   cntr     (out, N)  : registered counter state
//   phase    (out, PW) : position of cntr in the sequence
//   wrap     (out, 1)  : one-cycle pulse when a step lands on the start value
//   err      (out, 1)  : cntr holds an illegal state for the registered mode
module cfg_ring_cntr
  import ring_cntr_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          dir,
  input  mode_t         mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  cntr,
  output logic [PW-1:0] phase,
  output logic          wrap,
  output logic          err
);

  generate
    if (N < 2) begin : g_bad_width
      $error("cfg_ring_cntr: N must be >= 2");
    end
  endgenerate

  mode_t        mode_q;
  logic [N-1:0] start_in;
  logic [N-1:0] start_q;
  logic [N-1:0] step_val;

  assign start_in = N'(start_val(mode));
  assign start_q  = N'(start_val(mode_q));

  // Twist inverts the bit that wraps around; ring passes it through unchanged.
  always_comb begin
    step_val = cntr;
    if (dir) begin
      step_val = {cntr[N-2:0], (mode_q == MODE_TWIST) ? ~cntr[N-1] : cntr[N-1]};
    end else begin
      step_val = {(mode_q == MODE_TWIST) ? ~cntr[0] : cntr[0], cntr[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cntr   <= start_in;
      mode_q <= mode;
      wrap   <= 1'b0;
    end else if (mode != mode_q) begin
      cntr   <= start_in;
      mode_q <= mode;
      wrap   <= 1'b0;
    end else if (load) begin
      cntr <= load_val;
      wrap <= 1'b0;
`ifdef CFG_RING_CNTR_SELF_CORRECT_EN
    end else if (err) begin
      cntr <= start_q;
      wrap <= 1'b0;
`endif
    end else if (en) begin
      cntr <= step_val;
      wrap <= (step_val == start_q);
    end else begin
      wrap <= 1'b0;
    end
  end

  ring_cntr_phase_dec #(
    .N  (N),
    .PW (PW)
  ) u_phase_dec (
    .cntr  (cntr),
    .mode  (mode_q),
    .phase (phase),
    .err   (err)
  );

endmodule

// File: tb/tb_cfg_ring_cntr.sv
// tb/tb_cfg_ring_cntr.sv - directed self-checking bench for cfg_ring_cntr at N=4
module tb_cfg_ring_cntr;
  import ring_cntr_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  mode_t      mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] cntr;
  logic [2:0] phase;
  logic       wrap;
  logic       err;

  int n_checks;
  int n_fail;

  cfg_ring_cntr #(.N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .cntr     (cntr),
    .phase    (phase),
    .wrap     (wrap),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] c, input logic [2:0] p,
                             input logic w, input logic e);
    check({tag, ".cntr"},  32'(cntr),  32'(c));
    check({tag, ".phase"}, 32'(phase), 32'(p));
    check({tag, ".wrap"},  32'(wrap),  32'(w));
    check({tag, ".err"},   32'(err),   32'(e));
  endtask

  logic [3:0] tw_seq [8];
  logic [3:0] rg_seq [4];
  logic [2:0] rg_ph  [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    tw_seq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    rg_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rg_ph  = '{3'd3, 3'd2, 3'd1, 3'd0};

    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = MODE_TWIST; load = 1'b0; load_val = 4'b0000;
    tick();
    rst = 1'b0;
    check_state("reset_twist", 4'b0000, 3'd0, 1'b0, 1'b0);

    // Full twist-right revolution; wrap only on the return to 0000.
    en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_state($sformatf("twr%0d", i), tw_seq[i], 3'(i + 1), (i == 7), 1'b0);
    end
    en = 1'b0;
    tick();
    check_state("twr_wrap_drop", 4'b0000, 3'd0, 1'b0, 1'b0);

    // Twist left steps then right back onto start: wrap from the other direction.
    en = 1'b1; dir = 1'b1;
    tick(); check_state("twl0", 4'b0001, 3'd7, 1'b0, 1'b0);
    tick(); check_state("twl1", 4'b0011, 3'd6, 1'b0, 1'b0);
    dir = 1'b0;
    tick(); check_state("twl2", 4'b0001, 3'd7, 1'b0, 1'b0);
    tick(); check_state("twl3", 4'b0000, 3'd0, 1'b1, 1'b0);

    // Hold for 5 cycles mid-sequence, then reset with en high.
    tick(); tick();
    check_state("pre_hold", 4'b1100, 3'd2, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state($sformatf("hold%0d", i), 4'b1100, 3'd2, 1'b0, 1'b0);
    end
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    check_state("rst_mid", 4'b0000, 3'd0, 1'b0, 1'b0);

    // Load of an illegal twist pattern from 1100.
    en = 1'b1;
    tick(); tick();
    en = 1'b0;
    check_state("pre_load", 4'b1100, 3'd2, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'b0101;
    tick();
    load = 1'b0;
    check_state("load_bad", 4'b0101, 3'd0, 1'b0, 1'b1);
    tick();
`ifdef CFG_RING_CNTR_SELF_CORRECT_EN
    check_state("self_fix", 4'b0000, 3'd0, 1'b0, 1'b0);
`else
    check_state("bad_hold", 4'b0101, 3'd0, 1'b0, 1'b1);
    en = 1'b1;
    tick();
    en = 1'b0;
    check_state("bad_step", 4'b0010, 3'd0, 1'b0, 1'b1);
`endif
    load = 1'b1; load_val = 4'b0000;
    tick();
    load = 1'b0;
    check_state("load_start", 4'b0000, 3'd0, 1'b0, 1'b0);

    // Switch to ring: start value, no wrap.
    mode = MODE_RING;
    tick();
    check_state("to_ring", 4'b0001, 3'd0, 1'b0, 1'b0);
    en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_state($sformatf("rgl%0d", i), rg_seq[i], rg_ph[i], (i == 3), 1'b0);
    end
    dir = 1'b0;
    tick(); check_state("rgr0", 4'b1000, 3'd1, 1'b0, 1'b0);
    dir = 1'b1;
    tick(); check_state("rgr1", 4'b0001, 3'd0, 1'b1, 1'b0);
    tick(); tick();
    en = 1'b0;
    check_state("ring_at_0100", 4'b0100, 3'd2, 1'b0, 1'b0);

    // Ring -> twist mid-sequence.
    mode = MODE_TWIST;
    tick();
    check_state("to_twist", 4'b0000, 3'd0, 1'b0, 1'b0);

    // Mode change beats simultaneous load and en.
    en = 1'b1; dir = 1'b0;
    tick();
    check_state("pre_prio", 4'b1000, 3'd1, 1'b0, 1'b0);
    mode = MODE_RING; load = 1'b1; load_val = 4'b0110;
    tick();
    load = 1'b0; en = 1'b0;
    check_state("prio", 4'b0001, 3'd0, 1'b0, 1'b0);

    // Illegal ring state (not one-hot) loaded.
    load = 1'b1; load_val = 4'b0011;
    tick();
    load = 1'b0;
    check_state("ring_bad", 4'b0011, 3'd0, 1'b0, 1'b1);

    // Reset in ring mode.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_state("reset_ring", 4'b0001, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_ring_cntr.md
CFG_RING_CNTR -- requirements
Module: cfg_ring_cntr

Interface
REQ-001 Parameter N, default 4, sets the counter width; legal range is N >= 2 (elaboration error otherwise).
REQ-002 Parameter PW, default $clog2(2*N), sets the phase output width.
REQ-003 Port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port en, input, 1 bit: when high, advance one step.
REQ-006 Port dir, input, 1 bit: step direction; 0 = shift right, 1 = shift left.
REQ-007 Port mode, input, mode_t (1 bit): MODE_TWIST (0) selects Johnson; MODE_RING (1) selects one-hot ring.
REQ-008 Port load, input, 1 bit: when high, write load_val.
REQ-009 Port load_val, input, N bits: value written on load.
REQ-010 Port cntr, output, N bits: registered counter state.
REQ-011 Port phase, output, PW bits: position of cntr in the sequence.
REQ-012 Port wrap, output, 1 bit: registered one-cycle pulse.
REQ-013 Port err, output, 1 bit: high while cntr holds an illegal state.

Function
REQ-014 The start value SHALL be 0 in MODE_TWIST and 1 (bit 0 set) in MODE_RING.
REQ-015 A twist right step SHALL compute cntr <= {~cntr[0], cntr[N-1:1]}, and a twist left step SHALL compute cntr <= {cntr[N-2:0], ~cntr[N-1]}.
REQ-016 A ring right step SHALL compute cntr <= {cntr[0], cntr[N-1:1]}, and a ring left step SHALL compute cntr <= {cntr[N-2:0], cntr[N-1]}.
REQ-017 The block SHALL hold an internal registered copy of mode; when the mode input differs from it, the next edge SHALL load the new mode's start value, update the copy, and keep wrap low.
REQ-018 Priority per edge SHALL be: rst > mode change > load > self-correction (REQ-027) > en step > hold.
REQ-019 Load SHALL take effect on the next edge (1-cycle latency) regardless of en, and SHALL not assert wrap.
REQ-020 Wrap SHALL assert for exactly one cycle when an en step lands on the start value, in either direction; its period is 2N steps in twist mode and N steps in ring mode.
REQ-021 In twist mode, phase SHALL equal popcount(cntr) if cntr[0]=0, and 2N-popcount(cntr) if cntr[0]=1; for example, with N=4, 1000 gives 1, 1111 gives 4, and 0001 gives 7.
REQ-022 In ring mode, phase SHALL equal (N - index of the set bit) mod N.
REQ-023 Phase SHALL be 0 whenever err is high.
REQ-024 Legality SHALL be defined as: a twist state is legal iff it is one of the 2N Johnson patterns; a ring state is legal iff it is one-hot.
REQ-025 Err SHALL be combinational from cntr and the registered mode.

Reset
REQ-026 On rst, cntr SHALL take the start value of the mode input sampled that edge, the mode copy SHALL load from the mode input, and wrap SHALL be 0; rst mid-sequence SHALL abandon the sequence with no wrap pulse.

Configuration
REQ-027 With CFG_RING_CNTR_SELF_CORRECT_EN defined, an illegal state SHALL be replaced by the start value on the next edge, independent of en, so err is high for exactly one cycle.
REQ-028 Without CFG_RING_CNTR_SELF_CORRECT_EN, an illegal state SHALL persist and keep stepping per REQ-015/016 when en is high, and err SHALL stay high while the state is illegal.

Structure
REQ-029 Package ring_cntr_pkg SHALL hold typedef mode_t, constants MODE_TWIST and MODE_RING, and a start-value function.
REQ-030 Sub-module ring_cntr_phase_dec (parameter N; inputs cntr and mode; outputs phase and err) SHALL hold the combinational decode and legality check.

Verification (N=4)
REQ-031 Scenario: rst with MODE_TWIST, then en=1, dir=0 for 8 cycles -> cntr 0000,1000,1100,1110,1111,0111,0011,0001,0000; phase 0..7,0; wrap pulses once at return.
REQ-032 Scenario: MODE_RING, dir=1, en=1 -> cntr 0001,0010,0100,1000,0001; wrap pulses every 4 steps; phase 0,3,2,1,0.
REQ-033 Scenario: twist at 1100, load=1 with load_val 0101 -> cntr 0101 next cycle and err=1; with the macro, cntr returns to 0000 on the following cycle; without it, err stays 1.
REQ-034 Scenario: ring at 0100, mode switched to MODE_TWIST -> cntr 0000 next edge, wrap 0, err 0.
REQ-035 Scenario: en=0 for 5 cycles mid-sequence -> cntr, phase held and wrap 0; then rst asserted with en=1 -> start value, no wrap.
REQ-036 Scenario: load, en and mode change asserted in the same cycle -> the mode change wins and cntr equals the new start value.
